serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8: number of payload bits per frame (legal range 2..16).
REQ-002 Parameter SYNC, default 4'b1011: sync word that marks the start of a frame, matched MSB-first.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-005 Port din, input, 1: serial bit stream, sampled one bit per rising clk edge.
REQ-006 Port data_out, output, DATA_W: last good payload, MSB = first received payload bit.
REQ-007 Port valid, output, 1: single-cycle pulse when data_out is updated with a good frame.
REQ-008 Port perr, output, 1: single-cycle pulse when a frame fails its parity check.
REQ-009 Port busy, output, 1: high while in DATA or PARITY state.
REQ-010 Port frame_cnt, output, 8: count of good frames, saturating at 255.

Function
REQ-011 The FSM SHALL have three states: HUNT, DATA and PARITY; the reset state is HUNT.
REQ-012 In HUNT, a 4-bit history register SHALL shift din in LSB-first each cycle: hist <= {hist[2:0], din}.
REQ-013 In HUNT, the FSM SHALL move to DATA on the edge where {hist[2:0], din} == SYNC, with bit counter = 0.
  - Overlapping matches count (e.g. stream 1,1,0,1,1 matches at the 5th bit).
REQ-014 In DATA, each edge SHALL shift din into the payload register MSB-first and increment the bit counter.
REQ-015 In DATA, on the edge that captures bit DATA_W-1, the FSM SHALL move to PARITY.
REQ-016 In PARITY, din is the even-parity bit: XOR of the payload bits and din must equal 0.
REQ-017 On the PARITY edge with good parity:
  - data_out <= payload
  - valid = 1 for exactly the next cycle
  - frame_cnt increments, saturating at 255
REQ-018 On the PARITY edge with bad parity:
  - perr = 1 for exactly the next cycle
  - data_out and frame_cnt unchanged; valid stays 0
REQ-019 On the PARITY edge the FSM SHALL return to HUNT and clear hist to 0, so no sync bits are reused across frame boundaries.
REQ-020 The next frame's sync MAY begin on the cycle after the parity bit (back-to-back frames are supported).
REQ-021 Latency from sampling the parity bit to valid/perr SHALL be one cycle (registered outputs); valid and perr are never high together.
REQ-022 din is not examined for sync while in DATA or PARITY; a sync pattern inside the payload is treated as data.
REQ-023 busy SHALL be registered and reflect the current state (DATA or PARITY).

Reset
REQ-024 While rstn = 0, the block SHALL hold these values:
  - state = HUNT
  - hist, payload, bit counter = 0
  - data_out = 0, frame_cnt = 0
  - valid, perr, busy = 0
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with no valid/perr pulse.
REQ-026 After reset release, sync hunting SHALL restart from an empty history.

Structure
REQ-027 A shared package SHALL hold:
  - the state enumeration (HUNT, DATA, PARITY)
  - the default SYNC constant and SYNC width (4)
  - the frame_cnt width (8)
REQ-028 Sync matching SHALL be a sub-module, sync_detect: clk, rstn, din, enable, clear -> hit (combinational from hist and din).
REQ-029 The top SHALL contain the FSM, the payload shift register, the bit counter, the parity accumulator and the output registers.

Verification
REQ-030 Reset, then din = 1,0,1,1, then 1,0,1,0,0,1,0,1 (0xA5), then parity 0 -> data_out = 0xA5, valid high one cycle, frame_cnt = 1, perr = 0.
REQ-031 Same frame with parity bit 1 -> perr high one cycle, valid = 0, data_out = 0 (unchanged), frame_cnt = 0.
REQ-032 Prefix 1,1 then 0,1,1 + 0x3C + parity 0 -> overlapping sync detected, data_out = 0x3C, valid pulses.
REQ-033 Two back-to-back good frames, 0x0F then 0xF0, with no idle cycles between -> two valid pulses 13 cycles apart, frame_cnt = 2.
REQ-034 rstn pulsed low after 4 payload bits, then a full 0x81 frame -> no pulse for the aborted frame, then data_out = 0x81, frame_cnt = 1.
REQ-035 Payload 0xB0 (contains 1011) followed by parity 1 -> payload is not treated as sync, data_out = 0xB0, valid pulses.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_rx_pkg;
    typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

    localparam int SYNC_W = 4;
    localparam logic [SYNC_W-1:0] SYNC_DEFAULT = 4'b1011;
    localparam int CNT_W = 8;
endpackage

// File: rtl/serial_frame_rx_sync_detect.sv
// Sync word matcher: shifts din into a history while enabled and flags a match
// combinationally on the edge that completes the sync word.
module sync_detect
    import serial_frame_rx_pkg::*;
#(
    parameter logic [SYNC_W-1:0] SYNC = SYNC_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    input  logic enable,
    input  logic clear,
    output logic hit
);
    // The oldest history bit is shifted out before it can take part in a
    // match, so only the newest SYNC_W-1 bits are kept.
    logic [SYNC_W-2:0] hist;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       hist <= '0;
        else if (clear)  hist <= '0;
        else if (enable) hist <= {hist[SYNC_W-3:0], din};
    end

    assign hit = enable && ({hist, din} == SYNC);
endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: sync hunt, DATA_W payload bits MSB-first, even parity,
// registered valid/perr pulses and a saturating good-frame counter.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter logic [SYNC_W-1:0] SYNC   = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              din,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              perr,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state;
    logic [DATA_W-1:0] payload;
    logic [CW-1:0]     bitcnt;
    logic              par;
    logic              hit;

    sync_detect #(.SYNC(SYNC)) u_sync (
        .clk    (clk),
        .rstn   (rstn),
        .din    (din),
        .enable (state == HUNT),
        .clear  (state == PARITY),
        .hit    (hit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= HUNT;
            payload   <= '0;
            bitcnt    <= '0;
            par       <= 1'b0;
            data_out  <= '0;
            frame_cnt <= '0;
            valid     <= 1'b0;
            perr      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= 1'b0;
            perr  <= 1'b0;
            case (state)
                HUNT: begin
                    if (hit) begin
                        state  <= DATA;
                        bitcnt <= '0;
                        par    <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                DATA: begin
                    payload <= {payload[DATA_W-2:0], din};
                    par     <= par ^ din;
                    bitcnt  <= bitcnt + 1'b1;
                    if (bitcnt == CW'(DATA_W - 1)) state <= PARITY;
                end
                PARITY: begin
                    // Even parity: payload XOR parity bit must be zero.
                    if ((par ^ din) == 1'b0) begin
                        data_out <= payload;
                        valid    <= 1'b1;
                        if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
                    end else begin
                        perr <= 1'b1;
                    end
                    state <= HUNT;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: each scenario task drives bits and checks inline.
module tb_serial_frame_rx;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       din = 1'b0;
    logic [7:0] data_out;
    logic       valid, perr, busy;
    logic [7:0] frame_cnt;

    int pass_cnt = 0;
    int total = 0;
    int vld_seen = 0;
    int perr_seen = 0;
    int cyc = 0;

    serial_frame_rx #(.DATA_W(8), .SYNC(4'b1011)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din       (din),
        .data_out  (data_out),
        .valid     (valid),
        .perr      (perr),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) vld_seen <= vld_seen + 1;
        if (perr)  perr_seen <= perr_seen + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send_bit(input logic b);
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(p);
    endtask

    task automatic do_reset();
        din  = 1'b0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        din  = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({data_out, frame_cnt, valid, perr, busy} !== 19'd0)
            $display("FAIL reset_state: got do=%h cnt=%0d v=%b p=%b b=%b, want all zero",
                     data_out, frame_cnt, valid, perr, busy);
        else pass_cnt++;
        rstn = 1'b1;
        din  = 1'b0;
    endtask

    task automatic test_good_frame();
        int v0;
        do_reset();
        v0 = vld_seen;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        total++;
        if (busy !== 1'b1) $display("FAIL busy_in_data: got %b want 1", busy);
        else pass_cnt++;
        for (int i = 7; i >= 0; i--) send_bit(8'hA5 >> i);
        send_bit(1'b0);
        total++;
        if (valid !== 1'b1 || perr !== 1'b0 || data_out !== 8'hA5 || frame_cnt !== 8'd1)
            $display("FAIL good_frame: got v=%b p=%b do=%h cnt=%0d, want v=1 p=0 do=a5 cnt=1",
                     valid, perr, data_out, frame_cnt);
        else pass_cnt++;
        send_bit(1'b0);
        total++;
        if (valid !== 1'b0 || busy !== 1'b0 || vld_seen - v0 != 1)
            $display("FAIL good_frame_pulse: got v=%b b=%b pulses=%0d, want v=0 b=0 pulses=1",
                     valid, busy, vld_seen - v0);
        else pass_cnt++;
    endtask

    task automatic test_bad_parity();
        int p0;
        do_reset();
        p0 = perr_seen;
        send_frame(8'hA5, 1'b1);
        total++;
        if (perr !== 1'b1 || valid !== 1'b0 || data_out !== 8'h00 || frame_cnt !== 8'd0)
            $display("FAIL bad_parity: got p=%b v=%b do=%h cnt=%0d, want p=1 v=0 do=00 cnt=0",
                     perr, valid, data_out, frame_cnt);
        else pass_cnt++;
        send_bit(1'b0);
        total++;
        if (perr !== 1'b0 || perr_seen - p0 != 1)
            $display("FAIL bad_parity_pulse: got p=%b pulses=%0d, want p=0 pulses=1",
                     perr, perr_seen - p0);
        else pass_cnt++;
    endtask

    task automatic test_overlap();
        do_reset();
        send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(8'h3C >> i);
        send_bit(1'b0);
        total++;
        if (valid !== 1'b1 || data_out !== 8'h3C)
            $display("FAIL overlap_sync: got v=%b do=%h, want v=1 do=3c", valid, data_out);
        else pass_cnt++;
        send_bit(1'b0);
    endtask

    task automatic test_back_to_back();
        int t1, t2, v0;
        do_reset();
        v0 = vld_seen;
        send_frame(8'h0F, 1'b0);
        t1 = cyc;
        total++;
        if (valid !== 1'b1 || data_out !== 8'h0F)
            $display("FAIL b2b_first: got v=%b do=%h, want v=1 do=0f", valid, data_out);
        else pass_cnt++;
        send_frame(8'hF0, 1'b0);
        t2 = cyc;
        total++;
        if (valid !== 1'b1 || data_out !== 8'hF0 || frame_cnt !== 8'd2 || t2 - t1 != 13)
            $display("FAIL b2b_second: got v=%b do=%h cnt=%0d gap=%0d, want v=1 do=f0 cnt=2 gap=13",
                     valid, data_out, frame_cnt, t2 - t1);
        else pass_cnt++;
        send_bit(1'b0);
        total++;
        if (vld_seen - v0 != 2)
            $display("FAIL b2b_pulses: got %0d want 2", vld_seen - v0);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int v0, p0;
        do_reset();
        v0 = vld_seen;
        p0 = perr_seen;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        rstn = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0 || perr !== 1'b0)
            $display("FAIL abort_async: got b=%b v=%b p=%b, want 0 0 0", busy, valid, perr);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        send_frame(8'h81, 1'b0);
        total++;
        if (valid !== 1'b1 || data_out !== 8'h81 || frame_cnt !== 8'd1)
            $display("FAIL abort_then_frame: got v=%b do=%h cnt=%0d, want v=1 do=81 cnt=1",
                     valid, data_out, frame_cnt);
        else pass_cnt++;
        send_bit(1'b0);
        total++;
        if (vld_seen - v0 != 1 || perr_seen - p0 != 0)
            $display("FAIL abort_pulses: got valid=%0d perr=%0d, want valid=1 perr=0",
                     vld_seen - v0, perr_seen - p0);
        else pass_cnt++;
    endtask

    task automatic test_sync_in_payload();
        do_reset();
        send_frame(8'hB0, 1'b1);
        total++;
        if (valid !== 1'b1 || perr !== 1'b0 || data_out !== 8'hB0)
            $display("FAIL sync_in_payload: got v=%b p=%b do=%h, want v=1 p=0 do=b0",
                     valid, perr, data_out);
        else pass_cnt++;
        send_bit(1'b0);
    endtask

    task automatic test_saturation();
        int v0;
        do_reset();
        v0 = vld_seen;
        for (int n = 0; n < 256; n++) send_frame(n[7:0] ^ 8'h5A, ^(n[7:0] ^ 8'h5A));
        total++;
        if (valid !== 1'b1 || frame_cnt !== 8'd255 || data_out !== (8'hFF ^ 8'h5A))
            $display("FAIL cnt_saturate: got v=%b cnt=%0d do=%h, want v=1 cnt=255 do=a5",
                     valid, frame_cnt, data_out);
        else pass_cnt++;
        send_bit(1'b0);
        total++;
        if (vld_seen - v0 != 256)
            $display("FAIL cnt_saturate_pulses: got %0d want 256", vld_seen - v0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_overlap();
        test_back_to_back();
        test_abort();
        test_sync_in_payload();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
